// File: rtl/fetch_unit.sv
// Instruction fetch stage: drives the instruction-memory request, buffers one
// word across decode stalls and discards in-flight fetches on redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  pcsrc,
  input  logic [31:0] branch_target,
  input  logic [31:0] jump_target,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic        req_r, req_s;
  logic [31:0] buf_instr_r, buf_instr_s;
  logic [31:0] buf_pc4_r, buf_pc4_s;
  logic [31:0] tgt_r, tgt_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc4_r, pc4_s;
  logic        valid_r, valid_s;

  logic        ack_s;
  logic        redirect_s;
  logic [31:0] target_s;
  logic [31:0] pc_plus4_s;

  assign imem_req    = req_r;
  assign imem_addr   = pc_r;
  assign if_id_instr = instr_r;
  assign if_id_pc4   = pc4_r;
  assign if_id_valid = valid_r;

  // Next-state and next-value logic for the whole fetch stage
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    req_s       = req_r;
    buf_instr_s = buf_instr_r;
    buf_pc4_s   = buf_pc4_r;
    tgt_s       = tgt_r;
    instr_s     = instr_r;
    pc4_s       = pc4_r;
    valid_s     = valid_r;

    ack_s      = imem_ack & req_r;
    redirect_s = (pcsrc != 2'b00) & valid_r & ~stall;
    target_s   = pcsrc[1] ? {jump_target[31:2], 2'b00} : {branch_target[31:2], 2'b00};
    pc_plus4_s = pc_r + 32'd4;

    case (state_r)
      FETCH: begin
        if (redirect_s) begin
          valid_s = 1'b0;
          // The outstanding request must complete at its old address first.
          if (req_r && !ack_s) begin
            tgt_s   = target_s;
            state_s = DRAIN;
          end else begin
            pc_s  = target_s;
            req_s = 1'b1;
          end
        end else if (!req_r) begin
          req_s = 1'b1;
        end else if (ack_s) begin
          pc_s = pc_plus4_s;
          if (stall) begin
            buf_instr_s = imem_rdata;
            buf_pc4_s   = pc_plus4_s;
            req_s       = 1'b0;
            state_s     = HOLD;
          end else begin
            instr_s = imem_rdata;
            pc4_s   = pc_plus4_s;
            valid_s = 1'b1;
          end
        end else begin
          // Decode consumed the word with nothing new arriving: insert a bubble.
          valid_s = stall ? valid_r : 1'b0;
        end
      end
      HOLD: begin
        if (redirect_s) begin
          pc_s        = target_s;
          valid_s     = 1'b0;
          req_s       = 1'b1;
          buf_instr_s = 32'h0000_0000;
          buf_pc4_s   = 32'h0000_0000;
          state_s     = FETCH;
        end else if (!stall) begin
          instr_s = buf_instr_r;
          pc4_s   = buf_pc4_r;
          valid_s = 1'b1;
          req_s   = 1'b1;
          state_s = FETCH;
        end else begin
          state_s = HOLD;
        end
      end
      DRAIN: begin
        if (ack_s) begin
          pc_s    = tgt_r;
          req_s   = 1'b1;
          state_s = FETCH;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        state_s = FETCH;
        req_s   = 1'b0;
        valid_s = 1'b0;
      end
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= FETCH;
      pc_r        <= RESET_PC;
      req_r       <= 1'b0;
      buf_instr_r <= 32'h0000_0000;
      buf_pc4_r   <= 32'h0000_0000;
      tgt_r       <= 32'h0000_0000;
      instr_r     <= 32'h0000_0000;
      pc4_r       <= 32'h0000_0000;
      valid_r     <= 1'b0;
    end else begin
      state_r     <= state_s;
      pc_r        <= pc_s;
      req_r       <= req_s;
      buf_instr_r <= buf_instr_s;
      buf_pc4_r   <= buf_pc4_s;
      tgt_r       <= tgt_s;
      instr_r     <= instr_s;
      pc4_r       <= pc4_s;
      valid_r     <= valid_s;
    end
  end

endmodule
